// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for an 8-digit common-anode seven-segment display.
//   It captures eight 6-bit display codes once per frame into shadow
//   registers, so a code that changes mid-frame cannot tear the picture. It
//   then scans one digit per slot. Each slot begins with a short dark gap to
//   suppress ghosting. All outputs come straight from flops.
//
//   Optional feature macro: DISP_BLINK_EN
//     defined   -> adds input 'blink' and a frame-based blink phase. While
//                  blink=1 and phase=1, all anodes are forced off.
//     undefined -> no blink port; the display is never forced dark.
//
// Ports
//   clock       in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-high
//   d1..d8      in   6  code {blank, char[3:0], dp}; d1 = leftmost digit
//   blink       in   1  blink request (DISP_BLINK_EN only)
//   an_n        out  8  anode enables, active-low; an_n[7] = d1 .. an_n[0] = d8
//   seg_n       out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp_n        out  1  decimal point, active-low
//   frame_tick  out  1  one-cycle pulse on the cycle after the shadow reload
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int PRESCALE = 100000,
    parameter int DEADTIME = 16,
    parameter int BLINK_FR = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
`ifdef DISP_BLINK_EN
    input  logic       blink,
`endif
    output logic [7:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_tick
);

    localparam int             PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW:0]    DEAD     = (PW + 1)'(DEADTIME);

    logic [PW-1:0] pre_cnt_reg;
    logic [2:0]    slot_reg;
    logic          first_reg;
    logic [5:0]    shadow_reg [8];
    logic [5:0]    d_arr      [8];
    logic [7:0]    an_onehot;
    logic          terminal;
    logic          load;
    logic          force_dark;

    logic [7:0]    an_reg,  an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg,  dp_next;
    logic          frame_tick_reg;
    logic [5:0]    code_cur;
    logic          dark;

    always_comb begin
        d_arr[0] = d1;
        d_arr[1] = d2;
        d_arr[2] = d3;
        d_arr[3] = d4;
        d_arr[4] = d5;
        d_arr[5] = d6;
        d_arr[6] = d7;
        d_arr[7] = d8;
    end

    // Slot k lights the anode an_n[7-k].
    for (genvar gi = 0; gi < 8; gi++) begin : g_anode
        assign an_onehot[gi] = (slot_reg == 3'(7 - gi));
    end

    assign terminal = (pre_cnt_reg == PRE_LAST);
    // The first terminal count after reset also reloads the shadows. This
    // lets the display come alive without waiting for a full blank frame.
    assign load     = terminal && ((slot_reg == 3'd7) || first_reg);

    function automatic logic [6:0] decode(input logic [3:0] ch);
        logic [6:0] s;
        case (ch)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h61;
            4'hC: s = 7'h41;  4'hD: s = 7'h0C;  4'hE: s = 7'h06;  default: s = 7'h07;
        endcase
        return s;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt_reg <= '0;
            slot_reg    <= 3'd0;
            first_reg   <= 1'b1;
        end else if (terminal) begin
            pre_cnt_reg <= '0;
            slot_reg    <= slot_reg + 3'd1;
            first_reg   <= 1'b0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) shadow_reg[k] <= 6'b100000;
        end else if (load) begin
            for (int k = 0; k < 8; k++) shadow_reg[k] <= d_arr[k];
        end
    end

`ifdef DISP_BLINK_EN
    localparam int            FW      = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FR - 1);

    logic [FW-1:0] frame_cnt_reg;
    logic          phase_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (!blink) begin
            frame_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (frame_tick_reg) begin
            if (frame_cnt_reg == FR_LAST) begin
                frame_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign force_dark = blink && phase_reg;
`else
    assign force_dark = 1'b0;
`endif

    always_comb begin
        code_cur = shadow_reg[slot_reg];
        dark     = ({1'b0, pre_cnt_reg} < DEAD) || code_cur[5] || force_dark;
        an_next  = 8'hFF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (!dark) begin
            an_next  = ~an_onehot;
            seg_next = decode(code_cur[4:1]);
            dp_next  = ~code_cur[0];
        end
    end

    // The outputs are registered, so the anode lines can only change at a
    // clock edge. At most one of them is low at any time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an_reg         <= 8'hFF;
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            frame_tick_reg <= load;
        end
    end

    assign an_n       = an_reg;
    assign seg_n      = seg_reg;
    assign dp_n       = dp_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Scoreboard bench for seg7_scan_driver (PRESCALE=4, DEADTIME=1, BLINK_FR=2).
//   A cycle reference model pushes the expected registered outputs at each
//   rising edge. The checker pops one entry at each falling edge and compares
//   it with the DUT. The bench also checks directly the reset darkness,
//   the first-tick latency and the frame period.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int P  = 4;
    localparam int DT = 1;
    localparam int BF = 2;
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h61, 7'h41, 7'h0C, 7'h06, 7'h07 };
    localparam logic [16:0] DARK = {8'hFF, 7'h7F, 1'b1, 1'b0};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] d [8];
    logic       blink_drv = 1'b0;
    logic [7:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_tick;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    seg7_scan_driver #(.PRESCALE(P), .DEADTIME(DT), .BLINK_FR(BF)) dut (
        .clock      (clock),
        .reset      (reset),
        .d1         (d[0]),
        .d2         (d[1]),
        .d3         (d[2]),
        .d4         (d[3]),
        .d5         (d[4]),
        .d6         (d[5]),
        .d7         (d[6]),
        .d8         (d[7]),
`ifdef DISP_BLINK_EN
        .blink      (blink_drv),
`endif
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [16:0] exp_q [$];
    int          m_pre, m_slot, m_fcnt;
    logic        m_first, m_ft, m_phase;
    logic [5:0]  m_sh [8];

    always @(posedge clock) begin
        logic [5:0] code;
        logic       dark, load;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (reset) begin
            m_pre = 0; m_slot = 0; m_first = 1'b1; m_ft = 1'b0;
            m_fcnt = 0; m_phase = 1'b0;
            for (int k = 0; k < 8; k++) m_sh[k] = 6'b100000;
            exp_q.delete();
        end else begin
            code = m_sh[m_slot];
            dark = (m_pre < DT) || code[5] || (blink_drv && m_phase);
`ifndef DISP_BLINK_EN
            dark = (m_pre < DT) || code[5];
`endif
            e_an = 8'h80 >> m_slot;
            e_an = dark ? 8'hFF : ~e_an;
            e_seg = dark ? 7'h7F : SEG_TBL[code[4:1]];
            e_dp  = dark ? 1'b1 : ~code[0];
            load  = (m_pre == P - 1) && ((m_slot == 7) || m_first);
            exp_q.push_back({e_an, e_seg, e_dp, load});
            if (!blink_drv) begin
                m_fcnt = 0; m_phase = 1'b0;
            end else if (m_ft) begin
                if (m_fcnt == BF - 1) begin m_fcnt = 0; m_phase = ~m_phase; end
                else m_fcnt++;
            end
            m_ft = load;
            if (load) begin
                for (int k = 0; k < 8; k++) m_sh[k] = d[k];
                m_first = 1'b0;
            end
            if (m_pre == P - 1) begin m_pre = 0; m_slot = (m_slot + 1) % 8; end
            else m_pre++;
        end
    end

    always @(negedge clock) begin
        logic [16:0] e;
        if (!reset) begin
            if (exp_q.size() == 0) check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                check_eq("scan", {15'd0, an_n, seg_n, dp_n, frame_tick}, {15'd0, e});
            end
        end
    end

    // Returns the number of falling edges until frame_tick is seen (0 = none).
    task automatic wait_tick(input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clock);
            if (frame_tick) begin n = i; break; end
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < 8; k++) d[k] = 6'b100000;
        d[0] = 6'b010001;                       // char 8 with dp on the leftmost digit
        repeat (3) @(negedge clock);
        check_eq("rst_out", {15'd0, an_n, seg_n, dp_n, frame_tick}, {15'd0, DARK});
        #2 reset = 1'b0;
        wait_tick(10, n);
        check_eq("first_tick", n, 4);
        repeat (96) @(negedge clock);

        // chars 0..7, unblanked, no dp
        for (int k = 0; k < 8; k++) d[k] = {1'b0, 4'(k), 1'b0};
        wait_tick(40, n);
        wait_tick(40, n);
        check_eq("tick_period", n, 32);
        repeat (32) @(negedge clock);

        // change d3 in the middle of a frame
        d[2] = {1'b0, 4'd1, 1'b0};
        wait_tick(40, n);
        wait_tick(40, n);
        repeat (10) @(negedge clock);
        d[2] = {1'b0, 4'd2, 1'b0};
        wait_tick(40, n);
        check_eq("tick_period2", n, 22);
        repeat (40) @(negedge clock);

        // asynchronous reset during slot 5
        wait_tick(40, n);
        repeat (22) @(negedge clock);
        check_eq("slot5_lit", {24'd0, an_n}, {24'd0, 8'hFB});
        #2 reset = 1'b1;
        #1 check_eq("rst_async", {15'd0, an_n, seg_n, dp_n, frame_tick}, {15'd0, DARK});
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        wait_tick(10, n);
        check_eq("restart_tick", n, 4);
        repeat (64) @(negedge clock);

`ifdef DISP_BLINK_EN
        for (int k = 0; k < 8; k++) d[k] = {1'b0, 4'd8, 1'b0};
        blink_drv = 1'b1;
        repeat (12 * 32) @(negedge clock);
        blink_drv = 1'b0;
        repeat (64) @(negedge clock);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
